// File: rtl/fifo_rd_pack_pkg.sv
// Shared definitions for the FIFO read-side byte packer: default geometry,
// accumulator state encoding and counter-width helpers.
package fifo_rd_pack_pkg;

  // Default byte-lane width and lanes per packed output word.
  localparam int DEF_DSIZE = 8;
  localparam int DEF_RATIO = 4;

  // Width of the lane counter for the default geometry.
  localparam int DEF_CNT_W = $clog2(DEF_RATIO);

  // Width of the transferred-word counter.
  localparam int WCNT_W = 16;

  // Accumulator state encoding.
  localparam logic [1:0] ST_EMPTY      = 2'd0;
  localparam logic [1:0] ST_FILL       = 2'd1;
  localparam logic [1:0] ST_FLUSH_WAIT = 2'd2;

  // Lane counter width for an arbitrary ratio; never narrower than one bit.
  function automatic int cnt_width(input int ratio);
    return (ratio < 2) ? 1 : $clog2(ratio);
  endfunction

  // The accumulator state is fully implied by the pending flag and the
  // lane count, so it is decoded rather than stored separately.
  function automatic logic [1:0] acc_state(input logic pend, input logic cnt_zero);
    if (pend) begin
      return ST_FLUSH_WAIT;
    end else if (cnt_zero) begin
      return ST_EMPTY;
    end else begin
      return ST_FILL;
    end
  endfunction

endpackage

// File: rtl/fifo_rd_pack_out_reg.sv
// Output holding register for the packer: one word with lane mask, held
// stable until the downstream accepts it, plus a free-running transfer count.
module pack_out_reg
  import fifo_rd_pack_pkg::*;
#(
  parameter int W = 32,
  parameter int K = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [W-1:0]      load_data,
  input  logic [K-1:0]      load_keep,
  input  logic              out_ready,
  output logic [W-1:0]      out_data,
  output logic [K-1:0]      out_keep,
  output logic              out_valid,
  output logic              out_free,
  output logic [WCNT_W-1:0] word_cnt
);

  logic [W-1:0]      data_reg;
  logic [K-1:0]      keep_reg;
  logic              valid_reg;
  logic [WCNT_W-1:0] wcnt_reg;
  logic              xfer;

  assign xfer      = valid_reg & out_ready;
  // The slot can take a new word if it is empty or being emptied this edge.
  assign out_free  = !valid_reg | out_ready;

  assign out_data  = data_reg;
  assign out_keep  = keep_reg;
  assign out_valid = valid_reg;
  assign word_cnt  = wcnt_reg;

  // Load wins over transfer so back-to-back words flow without a bubble;
  // otherwise a transfer empties the slot and clears the stale word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_reg  <= '0;
      keep_reg  <= '0;
      valid_reg <= 1'b0;
    end else if (load) begin
      data_reg  <= load_data;
      keep_reg  <= load_keep;
      valid_reg <= 1'b1;
    end else if (xfer) begin
      data_reg  <= '0;
      keep_reg  <= '0;
      valid_reg <= 1'b0;
    end
  end

  // Count every accepted word, full or partial; wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_reg <= '0;
    end else if (xfer) begin
      wcnt_reg <= wcnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_rd_pack.sv
// Async-FIFO read-side packer: pops DSIZE-bit bytes and assembles them into
// RATIO-lane words, with an optional flush that emits a partially filled word.
module fifo_rd_pack
  import fifo_rd_pack_pkg::*;
#(
  parameter int DSIZE = DEF_DSIZE,
  parameter int RATIO = DEF_RATIO
) (
  input  logic                   rd_clk,
  input  logic                   rd_rst_n,
  input  logic [DSIZE-1:0]       rd_data,
  input  logic                   rd_empty,
  output logic                   rd_en,
  input  logic                   flush,
  output logic [DSIZE*RATIO-1:0] out_data,
  output logic [RATIO-1:0]       out_keep,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WCNT_W-1:0]      word_cnt
);

  localparam int CW = cnt_width(RATIO);
  localparam int WW = DSIZE * RATIO;
  localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

  // Accumulator state. Lanes at or above cnt_reg are always zero, so a
  // partial word needs no extra masking.
  logic [WW-1:0] acc_reg;
  logic [CW-1:0] cnt_reg;
  logic          pend_reg;
  logic          armed_reg;

  logic [1:0]       state;
  logic             last;
  logic             pop;
  logic             full;
  logic             part_req;
  logic             load;
  logic             out_free;
  logic [CW:0]      fill_w;
  logic [WW-1:0]    word_w;
  logic [RATIO-1:0] part_keep;
  logic [RATIO-1:0] load_keep;

  assign state = acc_state(pend_reg, cnt_reg == '0);
  assign last  = (cnt_reg == LAST);

  // Pop whenever a byte is available, no partial emit is waiting, and the
  // byte either fits in the accumulator or completes a word that the output
  // slot can take this edge. armed_reg holds pops off for the first cycle
  // after reset release. Deliberately independent of rd_data and flush.
  assign pop   = armed_reg & !rd_empty & (state != ST_FLUSH_WAIT) & (!last | out_free);
  assign rd_en = pop;

  // Completing pop: the full word goes straight to the output register and
  // swallows any coincident flush.
  assign full = pop & last;

  // Lanes filled once this edge's pop (if any) is counted.
  assign fill_w = {1'b0, cnt_reg} + {{CW{1'b0}}, pop};

  // A partial emit is wanted for a fresh flush with something to emit, or
  // for a flush still waiting on the output slot.
  assign part_req = !full & (pend_reg | (flush & (fill_w != '0)));

  assign load      = full | (part_req & out_free);
  assign load_keep = full ? {RATIO{1'b1}} : part_keep;

  // Per-lane view of the word as it stands after this edge's pop.
  for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
    logic wr_sel;
    assign wr_sel = pop & (cnt_reg == CW'(gi));
    assign word_w[gi*DSIZE +: DSIZE] = wr_sel ? rd_data : acc_reg[gi*DSIZE +: DSIZE];
    assign part_keep[gi] = ((CW+1)'(gi) < fill_w);
  end

  // Accumulator: clear on any emit, otherwise absorb the popped byte and
  // latch a flush that could not be emitted yet.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      acc_reg  <= '0;
      cnt_reg  <= '0;
      pend_reg <= 1'b0;
    end else if (load) begin
      acc_reg  <= '0;
      cnt_reg  <= '0;
      pend_reg <= 1'b0;
    end else begin
      acc_reg  <= word_w;
      cnt_reg  <= fill_w[CW-1:0];
      pend_reg <= part_req;
    end
  end

  // Arms the pop logic one edge after reset release.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      armed_reg <= 1'b0;
    end else begin
      armed_reg <= 1'b1;
    end
  end

  pack_out_reg #(
    .W(WW),
    .K(RATIO)
  ) u_out (
    .clk      (rd_clk),
    .rst_n    (rd_rst_n),
    .load     (load),
    .load_data(word_w),
    .load_keep(load_keep),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_keep (out_keep),
    .out_valid(out_valid),
    .out_free (out_free),
    .word_cnt (word_cnt)
  );

endmodule
